// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// control bit positions and the register-select decode helper.
package intc_pkg;

  localparam logic [7:0] OFF_PENDING = 8'h00;
  localparam logic [7:0] OFF_ENABLE  = 8'h04;
  localparam logic [7:0] OFF_TRIGGER = 8'h08;
  localparam logic [7:0] OFF_CLAIM   = 8'h0C;
  localparam logic [7:0] OFF_RAW     = 8'h10;
  localparam logic [7:0] OFF_CTRL    = 8'h14;

  localparam int          CTRL_GIE = 0;
  localparam logic [31:0] ID_NONE  = 32'd0;

  typedef enum logic [2:0] {
    SEL_PENDING,
    SEL_ENABLE,
    SEL_TRIGGER,
    SEL_CLAIM,
    SEL_RAW,
    SEL_CTRL,
    SEL_NONE
  } reg_sel_e;

  // Decodes a word index (byte address bits [7:2]) to a register select.
  function automatic reg_sel_e decode_reg(input logic [5:0] word);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (word == OFF_PENDING[7:2]) sel = SEL_PENDING;
    if (word == OFF_ENABLE[7:2])  sel = SEL_ENABLE;
    if (word == OFF_TRIGGER[7:2]) sel = SEL_TRIGGER;
    if (word == OFF_CLAIM[7:2])   sel = SEL_CLAIM;
    if (word == OFF_RAW[7:2])     sel = SEL_RAW;
    if (word == OFF_CTRL[7:2])    sel = SEL_CTRL;
    return sel;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source two-flop synchroniser with a trailing history flop,
// giving the synchronised level and a one-cycle rising-edge strobe.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic s,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= irq;
      sync <= meta;
      prev <= sync;
    end
  end

  assign s    = sync;
  assign rise = sync & ~prev;

endmodule

// File: rtl/irq_controller.sv
// Wishbone-slave interrupt controller: synchronises peripheral requests,
// latches edge sources, arbitrates by fixed priority and runs claim/complete.
module irq_controller
  import intc_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         wb_addr,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  input  logic               wb_we,
  input  logic [3:0]         wb_sel,
  input  logic               wb_stb,
  output logic               wb_ack,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] trigger;
  logic [NUM_IRQ-1:0] edge_pend;
  logic [NUM_IRQ-1:0] in_service;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] claim_mask;
  logic [NUM_IRQ-1:0] complete_mask;
  logic [NUM_IRQ-1:0] w1c_mask;
  logic               gie;
  logic               access;
  logic               wr;
  logic               rd;
  reg_sel_e           sel;
  logic [31:0]        claim_id;
  logic [31:0]        rd_data;
  logic               unused_bits;

  assign unused_bits = ^{wb_sel, wb_addr[1:0]};

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .irq  (irq_in[i]),
      .s    (s[i]),
      .rise (rise[i])
    );
  end

  // Edge sources report their latch, level sources follow the live input.
  assign pending = (trigger & edge_pend) | (~trigger & s);
  assign req     = pending & enable & ~in_service;

  assign access = wb_stb & ~wb_ack;
  assign wr     = access & wb_we;
  assign rd     = access & ~wb_we;
  assign sel    = decode_reg(wb_addr[7:2]);

  // Lowest index wins, so scan downwards and let lower sources overwrite.
  always_comb begin
    claim_id = ID_NONE;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) claim_id = 32'(i + 1);
    end
  end

  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    w1c_mask      = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      claim_mask[i]    = rd && (sel == SEL_CLAIM) && (claim_id == 32'(i + 1));
      complete_mask[i] = wr && (sel == SEL_CLAIM) && (wb_dat_i == 32'(i + 1));
    end
    if (wr && (sel == SEL_PENDING)) w1c_mask = wb_dat_i[NUM_IRQ-1:0];
  end

  always_comb begin
    rd_data = '0;
    case (sel)
      SEL_PENDING: rd_data[NUM_IRQ-1:0] = pending;
      SEL_ENABLE:  rd_data[NUM_IRQ-1:0] = enable;
      SEL_TRIGGER: rd_data[NUM_IRQ-1:0] = trigger;
      SEL_CLAIM:   rd_data = claim_id;
      SEL_RAW:     rd_data[NUM_IRQ-1:0] = s;
      SEL_CTRL:    rd_data[CTRL_GIE] = gie;
      default:     rd_data = '0;
    endcase
  end

  // All side effects land on the same edge that raises ack, so each
  // access acts exactly once; a new edge beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack     <= 1'b0;
      wb_dat_o   <= '0;
      enable     <= '0;
      trigger    <= '0;
      gie        <= 1'b0;
      edge_pend  <= '0;
      in_service <= '0;
      irq_out    <= 1'b0;
    end else begin
      wb_ack <= access;
      if (rd) wb_dat_o <= rd_data;
      if (wr && (sel == SEL_ENABLE))  enable  <= wb_dat_i[NUM_IRQ-1:0];
      if (wr && (sel == SEL_TRIGGER)) trigger <= wb_dat_i[NUM_IRQ-1:0];
      if (wr && (sel == SEL_CTRL))    gie     <= wb_dat_i[CTRL_GIE];
      edge_pend  <= trigger & ((edge_pend & ~(w1c_mask | claim_mask)) | rise);
      in_service <= (in_service & ~complete_mask) | claim_mask;
      irq_out    <= gie & (|req);
    end
  end

endmodule
